alu_rr_scheduler: RTL and testbench

//   Shares one 4-bit combinational alu instance between NREQ requesters. Arbitrates

---
 rtl/alu_rr_scheduler.sv | 134 +++++++++++++
 tb/tb_alu_rr_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// Round-robin front end sharing one external 4-bit ALU between NREQ requesters.
// Each accepted operation runs IDLE -> EXEC -> RESP and returns a tagged, registered result.
module alu_rr_scheduler #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [4*NREQ-1:0]   req_a,
    input  logic [4*NREQ-1:0]   req_b,
    input  logic [3*NREQ-1:0]   req_sel,
    output logic [NREQ-1:0]     req_ready,
    output logic [3:0]          alu_a,
    output logic [3:0]          alu_b,
    output logic [2:0]          alu_sel,
    input  logic [3:0]          alu_y,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [3:0]          rsp_y,
    output logic                rsp_err
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    state_e           r_state;
    state_e           w_state_next;

    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_id;
    logic [3:0]       r_a;
    logic [3:0]       r_b;
    logic [2:0]       r_sel;
    logic [IDW-1:0]   r_rsp_id;
    logic [3:0]       r_rsp_y;
    logic             r_rsp_err;

    logic [2*NREQ-1:0] w_dbl;
    logic              w_found;
    logic [IDW:0]      w_sum;
    logic [IDW-1:0]    w_grant;
    logic              w_err;
    logic [IDW-1:0]    w_ptr_next;

    // Rotate the request vector so bit 0 is the pointer position; first set bit wins.
    always_comb begin
        w_dbl   = {req_valid, req_valid} >> r_ptr;
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_dbl[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_ptr} + (IDW+1)'(k);
            end
        end
        w_grant = (w_sum >= (IDW+1)'(NREQ)) ? IDW'(w_sum - (IDW+1)'(NREQ)) : IDW'(w_sum);
    end

    always_comb begin
        req_ready = '0;
        if (r_state == StIdle && w_found && !rst) begin
            req_ready = NREQ'(1) << w_grant;
        end
    end

    assign w_err      = ((r_sel == 3'b011) || (r_sel == 3'b100)) && (r_b == 4'd0);
    assign w_ptr_next = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_found) w_state_next = StExec;
            StExec:  w_state_next = StResp;
            StResp:  if (rsp_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= '0;
            r_id      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_sel     <= '0;
            r_rsp_id  <= '0;
            r_rsp_y   <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_a   <= req_a[4*w_grant +: 4];
                        r_b   <= req_b[4*w_grant +: 4];
                        r_sel <= req_sel[3*w_grant +: 3];
                        r_id  <= w_grant;
                    end
                end
                StExec: begin
                    // The ALU result is undefined on divide/modulo by zero, so mask it.
                    r_rsp_y   <= w_err ? 4'd0 : alu_y;
                    r_rsp_id  <= r_id;
                    r_rsp_err <= w_err;
                end
                StResp: begin
                    if (rsp_ready) r_ptr <= w_ptr_next;
                end
                default: ;
            endcase
        end
    end

    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_sel   = r_sel;
    assign rsp_valid = (r_state == StResp);
    assign rsp_id    = r_rsp_id;
    assign rsp_y     = r_rsp_y;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Randomized self-checking bench for alu_rr_scheduler with a behavioural ALU and
// a round-robin reference model kept at transaction level.
module tb_alu_rr_scheduler;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [4*NREQ-1:0]   req_a;
    logic [4*NREQ-1:0]   req_b;
    logic [3*NREQ-1:0]   req_sel;
    logic [NREQ-1:0]     req_ready;
    logic [3:0]          alu_a;
    logic [3:0]          alu_b;
    logic [2:0]          alu_sel;
    logic [3:0]          alu_y;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [3:0]          rsp_y;
    logic                rsp_err;

    int n_checks = 0;
    int n_errors = 0;
    int m_ptr    = 0;

    logic [3:0] op_a [NREQ];
    logic [3:0] op_b [NREQ];
    logic [2:0] op_s [NREQ];

    alu_rr_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_y     (alu_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    // Result of the shared ALU for well-defined operations.
    function automatic logic [3:0] ref_y(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] s);
        int ia = int'(a);
        int ib = int'(b);
        int r;
        case (s)
            3'd0: r = ia + ib;
            3'd1: r = ia - ib;
            3'd2: r = int'(a & b);
            3'd3: r = (ib == 0) ? 0 : ia / ib;
            3'd4: r = (ib == 0) ? 0 : ia % ib;
            3'd5: r = int'(a ^ b);
            3'd6: r = int'(a | b);
            default: r = int'(~(a & b));
        endcase
        return 4'(r);
    endfunction

    // Environment ALU: garbage on divide/modulo by zero so masking is observable.
    always_comb begin
        alu_y = ref_y(alu_a, alu_b, alu_sel);
        if ((alu_sel == 3'd3 || alu_sel == 3'd4) && alu_b == 4'd0) alu_y = 4'hF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [NREQ-1:0] mask);
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[4*i +: 4]   = op_a[i];
            req_b[4*i +: 4]   = op_b[i];
            req_sel[3*i +: 3] = op_s[i];
        end
    endtask

    task automatic scramble_ops();
        req_a   = 16'($urandom);
        req_b   = 16'($urandom);
        req_sel = 12'($urandom);
    endtask

    // Called just after a rising edge with the DUT idle. Runs one full transaction.
    task automatic run_op(input logic [NREQ-1:0] mask, input int stall, output int gid);
        int         g;
        logic [3:0] ey;
        logic       ee;
        drive_ops();
        req_valid = mask;
        g = model_grant(mask);
        gid = g;
        #1;
        if (g < 0) begin
            check("idle_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
            check("idle_stay", 32'(rsp_valid), 32'd0);
            return;
        end
        check("req_ready", 32'(req_ready), 32'(1 << g));
        ey = ref_y(op_a[g], op_b[g], op_s[g]);
        ee = (op_s[g] == 3'd3 || op_s[g] == 3'd4) && op_b[g] == 4'd0;
        @(posedge clk); #1;
        req_valid = 4'($urandom);
        scramble_ops();
        check("exec_valid", 32'(rsp_valid), 32'd0);
        check("exec_ready", 32'(req_ready), 32'd0);
        check("alu_a", 32'(alu_a), 32'(op_a[g]));
        check("alu_b", 32'(alu_b), 32'(op_b[g]));
        check("alu_sel", 32'(alu_sel), 32'(op_s[g]));
        rsp_ready = (stall == 0);
        @(posedge clk); #1;
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_id", 32'(rsp_id), 32'(g));
        check("rsp_y", 32'(rsp_y), 32'(ey));
        check("rsp_err", 32'(rsp_err), 32'(ee));
        for (int s = 0; s < stall; s++) begin
            req_valid = 4'hF;
            @(posedge clk); #1;
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_id", 32'(rsp_id), 32'(g));
            check("bp_y", 32'(rsp_y), 32'(ey));
            check("bp_err", 32'(rsp_err), 32'(ee));
            if (s == stall - 1) rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("rsp_drop", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;
        req_valid = '0;
        m_ptr = (g + 1) % NREQ;
    endtask

    task automatic set_op(input int r, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] s);
        op_a[r] = a;
        op_b[r] = b;
        op_s[r] = s;
    endtask

    logic [3:0] exp_op_y [8];
    int         rr_order [6];

    initial begin
        int gid;
        exp_op_y = '{4'b1000, 4'b0010, 4'b0001, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1110};
        rr_order = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < NREQ; i++) set_op(i, 4'd0, 4'd0, 3'd0);
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        drive_ops();
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        check("rst_rsp", 32'({rsp_id, rsp_y, rsp_err}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single op on requester 1.
        set_op(1, 4'd5, 4'd3, 3'd0);
        run_op(4'b0010, 0, gid);
        check("single_id", 32'(gid), 32'd1);

        // All opcodes from requester 0.
        for (int s = 0; s < 8; s++) begin
            set_op(0, 4'b0101, 4'b0011, 3'(s));
            run_op(4'b0001, 0, gid);
            check("op_table", 32'(ref_y(4'b0101, 4'b0011, 3'(s))), 32'(exp_op_y[s]));
        end

        // Divide/modulo by zero, then add with b == 0.
        set_op(0, 4'd9, 4'd0, 3'b011);
        run_op(4'b0001, 0, gid);
        set_op(0, 4'd9, 4'd0, 3'b100);
        run_op(4'b0001, 0, gid);
        set_op(0, 4'd9, 4'd0, 3'b000);
        run_op(4'b0001, 0, gid);

        // Move the pointer to 0, then all requesters valid.
        set_op(3, 4'd1, 4'd2, 3'd0);
        run_op(4'b1000, 0, gid);
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < NREQ; i++) set_op(i, 4'(i + 1), 4'(n), 3'(n));
            run_op(4'b1111, 0, gid);
            check("rr_order", 32'(gid), 32'(rr_order[n]));
        end

        // Backpressure for five cycles, then next grant follows id + 1.
        for (int i = 0; i < NREQ; i++) set_op(i, 4'(7 - i), 4'(i), 3'(i));
        run_op(4'b1111, 5, gid);
        check("bp_grant", 32'(gid), 32'd2);
        run_op(4'b1111, 0, gid);
        check("bp_next", 32'(gid), 32'd3);

        // Pointer now 0; requester 2 leaves it at 3 before the reset test.
        set_op(2, 4'd6, 4'd5, 3'd6);
        run_op(4'b0100, 0, gid);
        set_op(1, 4'd12, 4'd10, 3'd5);
        set_op(3, 4'd11, 4'd13, 3'd7);
        drive_ops();
        req_valid = 4'b1010;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_rst_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_ptr = 0;
        req_valid = '0;
        run_op(4'b1010, 0, gid);
        check("post_rst_grant", 32'(gid), 32'd1);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                set_op(i, 4'($urandom), 4'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                       3'($urandom));
            end
            run_op(4'($urandom), int'($urandom_range(0, 3)), gid);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
